// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the byte-wide memory bus, with a ready
// timeout so a dead slave cannot stall a requester forever.
module mem_bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  output logic          s_read,
  output logic          s_write,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic [1:0]    grant,
  output logic          busy
);

  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          sel_q, sel_d;
  logic          op_q, op_d;  // 1 = write
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [TW-1:0] timer_q, timer_d;

  logic req0, req1;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    logic win;
    win     = 1'b0;
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    op_d    = op_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          win     = (req0 && req1) ? prio_q : req1;
          sel_d   = win;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          op_d    = win ? m1_write : m0_write;
          timer_d = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        timer_d = timer_q + 1'b1;
        if (s_ready) begin
          if (!op_q) rdata_d = s_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (TIMEOUT != 0 && timer_q == TimerLast) begin
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        prio_d  = ~sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic in_access, in_done;
  assign in_access = (state_q == StAccess);
  assign in_done   = (state_q == StDone);

  assign s_read  = in_access & ~op_q;
  assign s_write = in_access & op_q;
  assign s_addr  = in_access ? addr_q : '0;
  assign s_wdata = in_access ? wdata_q : '0;

  assign busy  = in_access | in_done;
  assign grant = busy ? {sel_q, ~sel_q} : 2'b00;

  assign m0_ready = in_done & ~sel_q;
  assign m1_ready = in_done & sel_q;
  assign m0_err   = m0_ready & err_q;
  assign m1_err   = m1_ready & err_q;
  assign m0_rdata = ~sel_q ? rdata_q : '0;
  assign m1_rdata = sel_q ? rdata_q : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with TIMEOUT=8, a second
// with the timeout disabled for the long-latency slave case.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic [7:0]  m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
  logic        s_ready = 0;
  logic [7:0]  m0_rdata, m1_rdata, s_wdata;
  logic        m0_ready, m0_err, m1_ready, m1_err, s_read, s_write, busy;
  logic [31:0] s_addr;
  logic [1:0]  grant;

  logic        b_m0_read = 0, b_s_ready = 0;
  logic [7:0]  b_s_rdata = 0;
  logic [7:0]  b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic        b_m0_ready, b_m0_err, b_m1_ready, b_m1_err, b_s_read, b_s_write, b_busy;
  logic [31:0] b_s_addr;
  logic [1:0]  b_grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .busy(busy)
  );

  mem_bus_arbiter #(.AW(32), .DW(8), .TIMEOUT(0)) dut_nto (
    .clk(clk), .rst(rst),
    .m0_read(b_m0_read), .m0_write(1'b0), .m0_addr(32'h0000_0050), .m0_wdata(8'h00),
    .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready), .m0_err(b_m0_err),
    .m1_read(1'b0), .m1_write(1'b0), .m1_addr(32'h0), .m1_wdata(8'h00),
    .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready), .m1_err(b_m1_err),
    .s_read(b_s_read), .s_write(b_s_write), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(b_s_rdata), .s_ready(b_s_ready), .grant(b_grant), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int bad;

    // Reset state
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sread", 32'(s_read), 0);
    rst = 1'b1;
    tick();

    // Reset mid-ACCESS abandons the transfer at once
    m1_read = 1; m1_addr = 32'h0000_0099;
    tick();
    chk("pre_rst_sread", 32'(s_read), 1);
    chk("pre_rst_grant", 32'(grant), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sread", 32'(s_read), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_m1rdy", 32'(m1_ready), 0);
    m1_read = 0;
    tick();
    rst = 1'b1;
    tick();

    // Contention: m0 write and m1 read together, m0 served first
    m0_write = 1; m0_addr = 32'h20; m0_wdata = 8'h3C;
    m1_read = 1; m1_addr = 32'h40;
    tick();
    chk("cont_swrite", 32'(s_write), 1);
    chk("cont_sread0", 32'(s_read), 0);
    chk("cont_swdata", 32'(s_wdata), 32'h3C);
    chk("cont_saddr0", s_addr, 32'h20);
    chk("cont_grant0", 32'(grant), 32'h1);
    s_ready = 1;
    tick();
    chk("cont_m0rdy", 32'(m0_ready), 1);
    chk("cont_m1rdy0", 32'(m1_ready), 0);
    chk("cont_done_swrite", 32'(s_write), 0);
    s_ready = 0; m0_write = 0;
    tick();
    chk("cont_idle_grant", 32'(grant), 0);
    chk("cont_idle_busy", 32'(busy), 0);
    tick();
    chk("cont_grant1", 32'(grant), 32'h2);
    chk("cont_sread1", 32'(s_read), 1);
    chk("cont_saddr1", s_addr, 32'h40);
    s_rdata = 8'h5A; s_ready = 1;
    tick();
    chk("cont_m1rdy", 32'(m1_ready), 1);
    chk("cont_m1rdata", 32'(m1_rdata), 32'h5A);
    chk("cont_m0rdy1", 32'(m0_ready), 0);
    m1_read = 0; s_ready = 0;
    tick();

    // Fairness: both request continuously, grants alternate starting with m0
    m0_read = 1; m0_addr = 32'h100; m1_read = 1; m1_addr = 32'h200; s_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fair_grant%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      tick();
    end
    m0_read = 0; m1_read = 0; s_ready = 0;
    tick();
    chk("fair_end_busy", 32'(busy), 0);

    // Single read, slave answers in the 4th ACCESS cycle
    m0_read = 1; m0_addr = 32'h10;
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (s_read !== 1'b1 || s_addr !== 32'h10 || m0_ready !== 1'b0) bad++;
      tick();
    end
    chk("rd_hold", 32'(bad), 0);
    chk("rd_saddr", s_addr, 32'h10);
    s_rdata = 8'hA5; s_ready = 1;
    tick();
    chk("rd_m0rdy", 32'(m0_ready), 1);
    chk("rd_m0rdata", 32'(m0_rdata), 32'hA5);
    chk("rd_m0err", 32'(m0_err), 0);
    chk("rd_m1rdy", 32'(m1_ready), 0);
    m0_read = 0; s_ready = 0;
    tick();
    chk("rd_pulse", 32'(m0_ready), 0);

    // Stray s_ready in IDLE produces nothing
    s_ready = 1;
    tick();
    tick();
    chk("stray_m0rdy", 32'(m0_ready), 0);
    chk("stray_m1rdy", 32'(m1_ready), 0);
    chk("stray_busy", 32'(busy), 0);
    s_ready = 0;

    // read and write both set: write wins
    m0_read = 1; m0_write = 1; m0_addr = 32'h30; m0_wdata = 8'h11;
    tick();
    chk("rw_swrite", 32'(s_write), 1);
    chk("rw_sread", 32'(s_read), 0);
    s_ready = 1;
    tick();
    chk("rw_m0rdy", 32'(m0_ready), 1);
    m0_read = 0; m0_write = 0; s_ready = 0;
    tick();

    // Timeout: dead slave, m1 read
    m1_read = 1; m1_addr = 32'h44;
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && m1_ready !== 1'b1; i++) begin
      if (s_read === 1'b1) cnt++;
      tick();
    end
    chk("to_cycles", 32'(cnt), 8);
    chk("to_m1rdy", 32'(m1_ready), 1);
    chk("to_m1err", 32'(m1_err), 1);
    chk("to_m1rdata", 32'(m1_rdata), 32'hFF);
    chk("to_m0rdy", 32'(m0_ready), 0);
    m1_read = 0;
    tick();
    chk("to_idle_busy", 32'(busy), 0);
    chk("to_idle_m1rdy", 32'(m1_ready), 0);

    // Timeout disabled: 200-cycle slave delay completes without error
    b_m0_read = 1;
    tick();
    bad = 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (b_s_read !== 1'b1 || b_m0_ready !== 1'b0 || b_m0_err !== 1'b0) bad++;
    end
    chk("nto_hold", 32'(bad), 0);
    b_s_rdata = 8'h77; b_s_ready = 1;
    tick();
    chk("nto_m0rdy", 32'(b_m0_ready), 1);
    chk("nto_m0err", 32'(b_m0_err), 0);
    chk("nto_m0rdata", 32'(b_m0_rdata), 32'h77);
    b_m0_read = 0; b_s_ready = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
